// File: rtl/hazard_pkg.sv
// Shared encodings and control bundle for the pipeline stall/flush scheduler.
package hazard_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned PC_SEL_W = 2;

   localparam logic [PC_SEL_W-1:0] PC_SEQ  = 2'd0;
   localparam logic [PC_SEL_W-1:0] PC_BR   = 2'd1;
   localparam logic [PC_SEL_W-1:0] PC_TRAP = 2'd2;
   localparam logic [PC_SEL_W-1:0] PC_EPC  = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_DWAIT      = 2'd1,
      ST_DWAIT_TRAP = 2'd2,
      ST_REDIRECT   = 2'd3
   } hz_state_t;

   typedef struct packed {
      logic stall_pc;
      logic stall_ifid;
      logic stall_idexe;
      logic stall_exemem;
      logic stall_memwb;
      logic flush_ifid;
      logic flush_idexe;
      logic flush_exemem;
      logic flush_memwb;
   } pipe_ctl_t;

   // Exception outranks xRET when both are reported at WB.
   function automatic logic [PC_SEL_W-1:0] trap_pc_sel(input logic except);
      return except ? PC_TRAP : PC_EPC;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EXE feeding a source register read in ID.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] exe_rd,
   input  logic             exe_we_reg,
   input  logic             exe_is_load,
   output logic             load_use_c
);

   // x0 is never a real producer, so it never stalls.
   always_comb begin
      load_use_c = 1'b0;
      if (exe_is_load && exe_we_reg && (exe_rd != '0)) begin
         load_use_c = (id_use_rs1 && (id_rs1 == exe_rd)) ||
                      (id_use_rs2 && (id_rs2 == exe_rd));
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline with dmem handshake
// ownership and wrapping performance counters.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned REDIRECT_CYC = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REG_W-1:0]    exe_rd,
   input  logic                exe_we_reg,
   input  logic                exe_is_load,
   input  logic                exe_br_taken,
   input  logic                mem_access,
   input  logic                dmem_ack,
   input  logic                wb_except,
   input  logic [1:0]          wb_ret,
   output logic                dmem_req,
   output logic                stall_pc,
   output logic                stall_ifid,
   output logic                stall_idexe,
   output logic                stall_exemem,
   output logic                stall_memwb,
   output logic                flush_ifid,
   output logic                flush_idexe,
   output logic                flush_exemem,
   output logic                flush_memwb,
   output logic [PC_SEL_W-1:0] pc_sel,
   output logic [CNT_W-1:0]    cnt_loaduse,
   output logic [CNT_W-1:0]    cnt_dmem_wait,
   output logic [CNT_W-1:0]    cnt_redirect
);

   localparam int unsigned RC_W     = (REDIRECT_CYC > 2) ? $clog2(REDIRECT_CYC) : 1;
   localparam int unsigned RC_LAST  = (REDIRECT_CYC > 1) ? (REDIRECT_CYC - 2) : 0;

   hz_state_t           state_q, state_d;
   logic                pend_q, pend_d;
   logic [PC_SEL_W-1:0] kind_q, kind_d;
   logic [RC_W-1:0]     rc_q, rc_d;
   logic [CNT_W-1:0]    cnt_lu_q, cnt_dw_q, cnt_rd_q;

   pipe_ctl_t           ctl;
   logic [PC_SEL_W-1:0] pc_sel_c;
   logic                req_c;
   logic                inc_lu, inc_dw, inc_rd;
   logic                do_trap, do_stall, do_adv;
   logic [PC_SEL_W-1:0] trap_sel_c;
   logic                trap_c;
   logic                load_use_c;

   hazard_detect u_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .exe_rd      (exe_rd),
      .exe_we_reg  (exe_we_reg),
      .exe_is_load (exe_is_load),
      .load_use_c  (load_use_c)
   );

   assign trap_c = wb_except || (wb_ret != 2'd0);

   // Next-state and pipeline control; the case picks an action, the tail applies it.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      kind_d     = kind_q;
      rc_d       = rc_q;
      ctl        = '0;
      pc_sel_c   = PC_SEQ;
      req_c      = 1'b0;
      inc_lu     = 1'b0;
      inc_dw     = 1'b0;
      inc_rd     = 1'b0;
      do_trap    = 1'b0;
      do_stall   = 1'b0;
      do_adv     = 1'b0;
      trap_sel_c = trap_pc_sel(wb_except);

      case (state_q)
         ST_RUN: begin
            if (trap_c) begin
               do_trap = 1'b1;
            end else begin
               req_c = mem_access;
               if (mem_access && !dmem_ack) begin
                  do_stall = 1'b1;
                  state_d  = ST_DWAIT;
               end else begin
                  do_adv = 1'b1;
               end
            end
         end
         ST_DWAIT: begin
            req_c  = 1'b1;
            inc_dw = 1'b1;
            if (trap_c && dmem_ack) begin
               do_trap = 1'b1;
            end else if (trap_c) begin
               do_stall = 1'b1;
               pend_d   = 1'b1;
               kind_d   = trap_sel_c;
               state_d  = ST_DWAIT_TRAP;
            end else if (dmem_ack) begin
               do_adv  = 1'b1;
               state_d = ST_RUN;
            end else begin
               do_stall = 1'b1;
            end
         end
         ST_DWAIT_TRAP: begin
            req_c  = 1'b1;
            inc_dw = 1'b1;
            if (dmem_ack) begin
               pend_d = 1'b0;
               if (pend_q) begin
                  do_trap    = 1'b1;
                  trap_sel_c = kind_q;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               do_stall = 1'b1;
            end
         end
         ST_REDIRECT: begin
            ctl.flush_ifid   = 1'b1;
            ctl.flush_idexe  = 1'b1;
            ctl.flush_exemem = 1'b1;
            ctl.flush_memwb  = 1'b1;
            if (rc_q == RC_W'(RC_LAST)) begin
               rc_d    = '0;
               state_d = ST_RUN;
            end else begin
               rc_d = rc_q + RC_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (do_trap) begin
         ctl.flush_ifid   = 1'b1;
         ctl.flush_idexe  = 1'b1;
         ctl.flush_exemem = 1'b1;
         ctl.flush_memwb  = 1'b1;
         pc_sel_c         = trap_sel_c;
         inc_rd           = 1'b1;
         rc_d             = '0;
         state_d          = (REDIRECT_CYC > 1) ? ST_REDIRECT : ST_RUN;
      end

      if (do_stall) begin
         ctl.stall_pc     = 1'b1;
         ctl.stall_ifid   = 1'b1;
         ctl.stall_idexe  = 1'b1;
         ctl.stall_exemem = 1'b1;
         ctl.flush_memwb  = 1'b1;
      end

      if (do_adv) begin
         if (exe_br_taken) begin
            ctl.flush_ifid  = 1'b1;
            ctl.flush_idexe = 1'b1;
            pc_sel_c        = PC_BR;
            inc_rd          = 1'b1;
         end else if (load_use_c) begin
            ctl.stall_pc    = 1'b1;
            ctl.stall_ifid  = 1'b1;
            ctl.flush_idexe = 1'b1;
            inc_lu          = 1'b1;
         end
      end
   end

   // State, pending-trap bookkeeping and redirect hold counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_RUN;
         pend_q  <= 1'b0;
         kind_q  <= PC_SEQ;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         kind_q  <= kind_d;
         rc_q    <= rc_d;
      end
   end

   // Wrapping performance counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_lu_q <= '0;
         cnt_dw_q <= '0;
         cnt_rd_q <= '0;
      end else begin
         if (inc_lu) cnt_lu_q <= cnt_lu_q + CNT_W'(1);
         if (inc_dw) cnt_dw_q <= cnt_dw_q + CNT_W'(1);
         if (inc_rd) cnt_rd_q <= cnt_rd_q + CNT_W'(1);
      end
   end

   assign dmem_req      = req_c;
   assign stall_pc      = ctl.stall_pc;
   assign stall_ifid    = ctl.stall_ifid;
   assign stall_idexe   = ctl.stall_idexe;
   assign stall_exemem  = ctl.stall_exemem;
   assign stall_memwb   = ctl.stall_memwb;
   assign flush_ifid    = ctl.flush_ifid;
   assign flush_idexe   = ctl.flush_idexe;
   assign flush_exemem  = ctl.flush_exemem;
   assign flush_memwb   = ctl.flush_memwb;
   assign pc_sel        = pc_sel_c;
   assign cnt_loaduse   = cnt_lu_q;
   assign cnt_dmem_wait = cnt_dw_q;
   assign cnt_redirect  = cnt_rd_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned RCYC  = 3;

   // {dmem_req, stall pc/ifid/idexe/exemem, stall_memwb, flush ifid/idexe/exemem/memwb, pc_sel}
   localparam logic [11:0] V_IDLE     = 12'b0_0000_0_0000_00;
   localparam logic [11:0] V_LU       = 12'b0_1100_0_0100_00;
   localparam logic [11:0] V_BR       = 12'b0_0000_0_1100_01;
   localparam logic [11:0] V_DSTALL   = 12'b1_1111_0_0001_00;
   localparam logic [11:0] V_DACK     = 12'b1_0000_0_0000_00;
   localparam logic [11:0] V_TRAP     = 12'b0_0000_0_1111_10;
   localparam logic [11:0] V_TRAP_ACK = 12'b1_0000_0_1111_10;
   localparam logic [11:0] V_RET_ACK  = 12'b1_0000_0_1111_11;
   localparam logic [11:0] V_REDIR    = 12'b0_0000_0_1111_00;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [4:0] id_rs1, id_rs2, exe_rd;
   logic id_use_rs1, id_use_rs2, exe_we_reg, exe_is_load, exe_br_taken;
   logic mem_access, dmem_ack, wb_except;
   logic [1:0] wb_ret;
   logic dmem_req, stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb;
   logic flush_ifid, flush_idexe, flush_exemem, flush_memwb;
   logic [1:0] pc_sel;
   logic [CNT_W-1:0] cnt_loaduse, cnt_dmem_wait, cnt_redirect;
   logic [11:0] obs;

   typedef struct packed {
      logic [11:0]      ctl;
      logic [CNT_W-1:0] lu;
      logic [CNT_W-1:0] dw;
      logic [CNT_W-1:0] rd;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   logic [CNT_W-1:0] e_lu = '0, e_dw = '0, e_rd = '0;
   exp_t  m_e;
   string m_n;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .REDIRECT_CYC(RCYC)) dut (
      .clk(clk), .rstn(rstn),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .exe_rd(exe_rd), .exe_we_reg(exe_we_reg), .exe_is_load(exe_is_load),
      .exe_br_taken(exe_br_taken), .mem_access(mem_access), .dmem_ack(dmem_ack),
      .wb_except(wb_except), .wb_ret(wb_ret), .dmem_req(dmem_req),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idexe(stall_idexe),
      .stall_exemem(stall_exemem), .stall_memwb(stall_memwb),
      .flush_ifid(flush_ifid), .flush_idexe(flush_idexe), .flush_exemem(flush_exemem),
      .flush_memwb(flush_memwb), .pc_sel(pc_sel), .cnt_loaduse(cnt_loaduse),
      .cnt_dmem_wait(cnt_dmem_wait), .cnt_redirect(cnt_redirect)
   );

   always #5 clk = ~clk;

   assign obs = {dmem_req, stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb,
                 flush_ifid, flush_idexe, flush_exemem, flush_memwb, pc_sel};

   // Monitor: compare the outputs presented in each checked cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         m_e = sb_q.pop_front();
         m_n = nm_q.pop_front();
         n_chk++;
         if (obs !== m_e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", m_n, obs, m_e.ctl);
         end
         n_chk++;
         if (cnt_loaduse !== m_e.lu) begin
            n_fail++;
            $display("FAIL %s cnt_loaduse: got %0d expected %0d", m_n, cnt_loaduse, m_e.lu);
         end
         n_chk++;
         if (cnt_dmem_wait !== m_e.dw) begin
            n_fail++;
            $display("FAIL %s cnt_dmem_wait: got %0d expected %0d", m_n, cnt_dmem_wait, m_e.dw);
         end
         n_chk++;
         if (cnt_redirect !== m_e.rd) begin
            n_fail++;
            $display("FAIL %s cnt_redirect: got %0d expected %0d", m_n, cnt_redirect, m_e.rd);
         end
      end
   end

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; exe_we_reg = 1'b0; exe_is_load = 1'b0;
      exe_br_taken = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
      wb_except = 1'b0; wb_ret = 2'b00;
   endtask

   // Queue the expectation for the current cycle, then advance one cycle.
   task automatic step(input logic [11:0] ctl, input string name);
      exp_t e;
      e.ctl = ctl; e.lu = e_lu; e.dw = e_dw; e.rd = e_rd;
      sb_q.push_back(e);
      nm_q.push_back(name);
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      rstn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      step(V_IDLE, "reset_idle");

      // load-use detection
      exe_is_load = 1'b1; exe_we_reg = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      step(V_LU, "lu_rs1"); e_lu++;
      idle(); step(V_IDLE, "lu_release");
      exe_is_load = 1'b1; exe_we_reg = 1'b1; exe_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      step(V_IDLE, "lu_x0");
      exe_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      step(V_LU, "lu_rs2"); e_lu++;
      id_use_rs2 = 1'b0; step(V_IDLE, "lu_rs2_unused");
      id_use_rs2 = 1'b1; exe_we_reg = 1'b0; step(V_IDLE, "lu_no_we");
      exe_we_reg = 1'b1; exe_is_load = 1'b0; step(V_IDLE, "lu_not_load");

      // branch redirect
      idle(); exe_br_taken = 1'b1; step(V_BR, "branch"); e_rd++;
      idle(); step(V_IDLE, "branch_done");

      // dmem with ack three cycles after request
      mem_access = 1'b1; step(V_DSTALL, "dm_c0");
      step(V_DSTALL, "dm_w1"); e_dw++;
      step(V_DSTALL, "dm_w2"); e_dw++;
      dmem_ack = 1'b1; step(V_DACK, "dm_ack"); e_dw++;
      idle(); step(V_IDLE, "dm_done");
      mem_access = 1'b1; dmem_ack = 1'b1; step(V_DACK, "dm_ack0");
      idle(); step(V_IDLE, "dm_ack0_done");

      // branch held behind a dmem stall, redirects once released
      mem_access = 1'b1; exe_br_taken = 1'b1; step(V_DSTALL, "br_dm_stall");
      exe_br_taken = 1'b0; dmem_ack = 1'b1; step(V_DACK, "br_dm_ack"); e_dw++;
      idle(); exe_br_taken = 1'b1; step(V_BR, "br_replay"); e_rd++;

      // exception arriving during a dmem wait
      idle(); mem_access = 1'b1; step(V_DSTALL, "tw_c0");
      wb_except = 1'b1; step(V_DSTALL, "tw_w1"); e_dw++;
      wb_except = 1'b0; step(V_DSTALL, "tw_w2"); e_dw++;
      dmem_ack = 1'b1; step(V_TRAP_ACK, "tw_ack"); e_dw++; e_rd++;
      idle(); step(V_REDIR, "tw_redir1");
      step(V_REDIR, "tw_redir2");
      step(V_IDLE, "tw_run");

      // xRET arriving during a dmem wait
      mem_access = 1'b1; step(V_DSTALL, "rw_c0");
      wb_ret = 2'b10; step(V_DSTALL, "rw_w1"); e_dw++;
      wb_ret = 2'b00; step(V_DSTALL, "rw_w2"); e_dw++;
      dmem_ack = 1'b1; step(V_RET_ACK, "rw_ack"); e_dw++; e_rd++;
      idle(); step(V_REDIR, "rw_redir1");
      step(V_REDIR, "rw_redir2");
      step(V_IDLE, "rw_run");

      // trap outranks branch and load-use; events during redirect ignored
      wb_except = 1'b1; wb_ret = 2'b01; exe_br_taken = 1'b1;
      exe_is_load = 1'b1; exe_we_reg = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      step(V_TRAP, "prio_trap"); e_rd++;
      step(V_REDIR, "prio_redir1");
      step(V_REDIR, "prio_redir2");
      idle(); step(V_IDLE, "prio_run");

      // synchronous reset while waiting on dmem
      mem_access = 1'b1; step(V_DSTALL, "rst_c0");
      step(V_DSTALL, "rst_w1"); e_dw++;
      rstn = 1'b0; idle();
      @(posedge clk); #1;
      rstn = 1'b1;
      e_lu = '0; e_dw = '0; e_rd = '0;
      step(V_IDLE, "rst_after");
      exe_is_load = 1'b1; exe_we_reg = 1'b1; exe_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
      step(V_LU, "rst_lu"); e_lu++;
      idle(); step(V_IDLE, "rst_lu_done");

      // scoreboard must drain within a bounded number of cycles
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
